// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM responder: FSM state encoding,
// default address map and external SRAM data width.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int unsigned SRAM_DW           = 16;

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter timing one SRAM half-access window of
// WAIT_CYCLES+1 cycles. start_i reloads it; last_o marks the final cycle of
// the window and pre_last_o the cycle just before it.
module sram_wait_timer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic last_o,
  output logic pre_last_o
);

  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  logic [3:0] cnt_q;

  // Reload on start, otherwise count down to zero and hold there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= WAIT_L;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign last_o     = (cnt_q == 4'd0);
  assign pre_last_o = (cnt_q == 4'd1);

endmodule

// File: rtl/sram_mem_responder.sv
// MEM-stage data-memory responder: each 32-bit access is split into a low
// and a high 16-bit access on an external asynchronous SRAM. ready stays
// low while an access is in flight so the pipeline can freeze.
// Optional: define SRAM_MEM_RESPONDER_PERF_EN to add rd_count, wr_count and
// stall_count performance counters.
module sram_mem_responder
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
`ifdef SRAM_MEM_RESPONDER_PERF_EN
  ,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count,
  output logic [31:0]        stall_count
`endif
);

  // With no wait states the single cycle of each half is also its last,
  // so the strobe is never raised on entry to a half.
  localparam logic STROBE_ON_ENTRY = (WAIT_CYCLES != 0);

  mem_state_e           state_q;
  logic                 op_wr_q;
  logic [SRAM_AW-2:0]   widx_q;
  logic [31:0]          wdata_q;
  logic [31:0]          read_data_q;
  logic [SRAM_AW-1:0]   sram_addr_q;
  logic [SRAM_DW-1:0]   dq_out_q;
  logic                 oe_q;
  logic                 we_n_q;

  logic                 req;
  logic [31:0]          offset;
  logic [SRAM_AW-2:0]   widx_in;
  logic                 unused_offset_bits;
  logic                 tmr_start;
  logic                 tmr_last;
  logic                 tmr_pre_last;

  assign req                = mem_r_en | mem_w_en;
  assign offset             = address - BASE_ADDR;
  assign widx_in            = offset[SRAM_AW:2];
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  // One timer serves both halves: reload on entry to LO and to HI.
  assign tmr_start = ((state_q == IDLE) & req) | ((state_q == LO) & tmr_last);

  sram_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start_i   (tmr_start),
    .last_o    (tmr_last),
    .pre_last_o(tmr_pre_last)
  );

  // Access sequencer; SRAM pins are registered one cycle ahead, so the write
  // strobe for the next cycle is decided from whether that cycle is the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      widx_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            op_wr_q     <= mem_w_en;
            widx_q      <= widx_in;
            wdata_q     <= write_data;
            sram_addr_q <= {widx_in, 1'b0};
            dq_out_q    <= write_data[15:0];
            oe_q        <= mem_w_en & STROBE_ON_ENTRY;
            we_n_q      <= ~(mem_w_en & STROBE_ON_ENTRY);
            state_q     <= LO;
          end
        end
        LO: begin
          if (tmr_last) begin
            if (!op_wr_q) read_data_q[15:0] <= sram_dq_in;
            sram_addr_q <= {widx_q, 1'b1};
            dq_out_q    <= wdata_q[31:16];
            oe_q        <= op_wr_q & STROBE_ON_ENTRY;
            we_n_q      <= ~(op_wr_q & STROBE_ON_ENTRY);
            state_q     <= HI;
          end else begin
            oe_q   <= op_wr_q & ~tmr_pre_last;
            we_n_q <= ~(op_wr_q & ~tmr_pre_last);
          end
        end
        HI: begin
          if (tmr_last) begin
            if (!op_wr_q) read_data_q[31:16] <= sram_dq_in;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            oe_q   <= op_wr_q & ~tmr_pre_last;
            we_n_q <= ~(op_wr_q & ~tmr_pre_last);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready       = ((state_q == IDLE) & ~req) | (state_q == DONE);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

`ifdef SRAM_MEM_RESPONDER_PERF_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;
  logic [31:0] stall_count_q;

  // Completed-access and stall-cycle counters, free-running with wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q    <= '0;
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      if (state_q == DONE && !op_wr_q) rd_count_q <= rd_count_q + 32'd1;
      if (state_q == DONE && op_wr_q)  wr_count_q <= wr_count_q + 32'd1;
      if (!ready)                      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: transaction-level model for the default
// instance checked every cycle, plus directed literal checks, and a second
// instance built with no wait states.
module tb_sram_mem_responder;

  localparam int W0  = 2;
  localparam int LAT = 2 * (W0 + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic        r_en, w_en;
  logic [31:0] addr, wdat;
  logic [31:0] rd0;
  logic        rdy0;
  logic [17:0] sa0;
  logic [15:0] dqo0, dqi0;
  logic        oe0, wen0;
`ifdef SRAM_MEM_RESPONDER_PERF_EN
  logic [31:0] rdc, wrc, stc;
`endif

  // zero-wait instance
  logic        r1, w1;
  logic [31:0] a1, wd1;
  logic [31:0] rd1;
  logic        rdy1;
  logic [17:0] sa1;
  logic [15:0] dqo1, dqi1;
  logic        oe1, wen1;

  sram_mem_responder u_dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (r_en),
    .mem_w_en   (w_en),
    .address    (addr),
    .write_data (wdat),
    .read_data  (rd0),
    .ready      (rdy0),
    .sram_addr  (sa0),
    .sram_dq_out(dqo0),
    .sram_dq_in (dqi0),
    .sram_dq_oe (oe0),
    .sram_we_n  (wen0)
`ifdef SRAM_MEM_RESPONDER_PERF_EN
    ,
    .rd_count   (rdc),
    .wr_count   (wrc),
    .stall_count(stc)
`endif
  );

  sram_mem_responder #(.WAIT_CYCLES(0)) u_dut0w (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (r1),
    .mem_w_en   (w1),
    .address    (a1),
    .write_data (wd1),
    .read_data  (rd1),
    .ready      (rdy1),
    .sram_addr  (sa1),
    .sram_dq_out(dqo1),
    .sram_dq_in (dqi1),
    .sram_dq_oe (oe1),
    .sram_we_n  (wen1)
`ifdef SRAM_MEM_RESPONDER_PERF_EN
    ,
    .rd_count   (),
    .wr_count   (),
    .stall_count()
`endif
  );

  // external SRAM models
  logic [15:0] sram0 [0:1023];
  logic [15:0] sram1 [0:1023];
  assign dqi0 = sram0[sa0[9:0]];
  assign dqi1 = sram1[sa1[9:0]];
  always @(posedge clk) if (!wen0) sram0[sa0[9:0]] <= dqo0;
  always @(posedge clk) if (!wen1) sram1[sa1[9:0]] <= dqo1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: k counts cycles since acceptance (1..LAT), 0 = idle.
  int          k = 0;
  bit          m_wr = 1'b0;
  int          m_widx = 0;
  logic [31:0] m_wd = '0;
  logic [31:0] exp_rd = '0;
  logic [31:0] mword [0:255];

  always @(posedge clk) begin
    if (rst) begin
      k      = 0;
      exp_rd = '0;
    end else if (k == 0) begin
      if (r_en | w_en) begin
        k      = 1;
        m_wr   = w_en;
        m_widx = int'((addr - 32'd1024) >> 2) & 255;
        m_wd   = wdat;
      end
    end else if (k == LAT) begin
      k = 0;
    end else begin
      k++;
      if (k == LAT) begin
        if (m_wr) mword[m_widx] = m_wd;
        else      exp_rd = mword[m_widx];
      end
    end
  end

  // Per-cycle comparison of the default instance against the model.
  always @(negedge clk) begin : cmp
    int          kk;
    int          pos;
    bit          hi;
    bit          strobe;
    bit          exp_rdy;
    logic [31:0] erd;
    kk      = rst ? 0 : k;
    erd     = rst ? 32'd0 : exp_rd;
    exp_rdy = (kk == 0 && !(r_en | w_en)) || kk == LAT;
    chk("ready", 32'(rdy0), 32'(exp_rdy));
    if (kk >= 1 && kk <= 2 * W0 + 2) begin
      hi     = kk > W0 + 1;
      pos    = hi ? kk - (W0 + 1) : kk;
      strobe = m_wr && pos <= W0;
      chk("sram_addr", 32'(sa0), 32'(m_widx * 2 + int'(hi)));
      chk("sram_we_n", 32'(wen0), 32'(!strobe));
      chk("sram_dq_oe", 32'(oe0), 32'(strobe));
      if (strobe) chk("sram_dq_out", 32'(dqo0), hi ? 32'(m_wd[31:16]) : 32'(m_wd[15:0]));
    end else begin
      chk("idle_we_n", 32'(wen0), 32'd1);
      chk("idle_oe", 32'(oe0), 32'd0);
    end
    if (exp_rdy) chk("read_data", rd0, erd);
  end

  // One access on the default instance; returns in the ready cycle with
  // the number of ready-low cycles observed.
  task automatic access(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    bit seen;
    @(posedge clk); #1;
    r_en = r; w_en = w; addr = a; wdat = d;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy0) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL access_timeout: no ready within 50 cycles for address %h", a);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    r_en = 1'b0; w_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    r_en = 1'b0; w_en = 1'b0; addr = '0; wdat = '0;
    r1 = 1'b0; w1 = 1'b0; a1 = '0; wd1 = '0;
    for (int i = 0; i < 1024; i++) begin
      sram0[i] = '0;
      sram1[i] = '0;
    end
    for (int i = 0; i < 256; i++) mword[i] = '0;
    sram1[510] = 16'h1111;
    sram1[511] = 16'h2222;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_we_n", 32'(wen0), 32'd1);
    chk("rst_oe", 32'(oe0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_read_data", rd0, 32'd0);

    // write then read word 0
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat);
    chk("wr_latency", 32'(lat), 32'd7);
    access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
    chk("rd_latency", 32'(lat), 32'd7);
    chk("rd_word0", rd0, 32'hDEADBEEF);
    chk("sram_0", 32'(sram0[0]), 32'h0000BEEF);
    chk("sram_1", 32'(sram0[1]), 32'h0000DEAD);
    idle(2);

    // reset in the middle of a write
    @(posedge clk); #1;
    w_en = 1'b1; addr = 32'd1064; wdat = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    chk("mid_write_we_n", 32'(wen0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; w_en = 1'b0;
    @(negedge clk);
    chk("abort_we_n", 32'(wen0), 32'd1);
    chk("abort_oe", 32'(oe0), 32'd0);
    chk("abort_ready", 32'(rdy0), 32'd1);
    chk("abort_read_data", rd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // back-to-back write @1028 then read @1024
    access(1'b0, 1'b1, 32'd1028, 32'h0BADC0DE, lat);
    chk("b2b_wr_latency", 32'(lat), 32'd7);
    access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
    chk("b2b_rd_latency", 32'(lat), 32'd7);
    chk("b2b_word0", rd0, 32'hDEADBEEF);
    chk("sram_2", 32'(sram0[2]), 32'h0000C0DE);
    chk("sram_3", 32'(sram0[3]), 32'h00000BAD);

    // both enables: write wins, read_data untouched
    access(1'b1, 1'b1, 32'd1032, 32'h12345678, lat);
    chk("both_latency", 32'(lat), 32'd7);
    chk("both_read_data", rd0, 32'hDEADBEEF);
    chk("sram_4", 32'(sram0[4]), 32'h00005678);
    chk("sram_5", 32'(sram0[5]), 32'h00001234);
    idle(2);

    // zero-wait instance: read @2044
    @(posedge clk); #1;
    r1 = 1'b1; a1 = 32'd2044;
    @(negedge clk);
    chk("w0_busy", 32'(rdy1), 32'd0);
    @(negedge clk);
    chk("w0_addr_lo", 32'(sa1), 32'd510);
    @(negedge clk);
    chk("w0_addr_hi", 32'(sa1), 32'd511);
    @(negedge clk);
    chk("w0_ready", 32'(rdy1), 32'd1);
    chk("w0_read_data", rd1, 32'h22221111);
    @(posedge clk); #1;
    r1 = 1'b0;
    idle(1);

`ifdef SRAM_MEM_RESPONDER_PERF_EN
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    access(1'b0, 1'b1, 32'd1040, 32'hA5A5_5A5A, lat);
    idle(1);
    access(1'b1, 1'b0, 32'd1024, 32'h0, lat);
    idle(1);
    access(1'b1, 1'b0, 32'd1040, 32'h0, lat);
    chk("perf_rd_data", rd0, 32'hA5A55A5A);
    idle(2);
    chk("rd_count", rdc, 32'd2);
    chk("wr_count", wrc, 32'd1);
    chk("stall_count", stc, 32'd21);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
